dram_uart_dumper: RTL and testbench

- Reads a block of bytes out of data memory once the processor finishes, and sends each byte on a UART TX line (8N1, LSB first).
- This is the reader/transmitter end of the data-memory path: the processor writes downsampled pixels into dRam, and this block reads them back and streams them off-chip.
- Sits in the top level beside dRam. It owns a dedicated read port (address, read enable) and receives dRam read data.

---
 rtl/dram_uart_dumper.sv | 198 +++++++++++++++++++
 tb/tb_dram_uart_dumper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_uart_dumper.sv
// ============================================================================
//  Module   : dram_uart_dumper
//  Purpose  : Reads a block of bytes from data memory after the processor
//             finishes and streams each byte out on a UART TX line
//             (8N1, LSB first).
//  Options  : DUMP_PARITY_EN - when defined, an even-parity bit is inserted
//             between the data bits and the stop bit (8E1 framing).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_uart_dumper #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int RD_LAT       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] d_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LAT_LAST = 16'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READ       = 3'd1,
        S_WAIT       = 3'd2,
        S_START_BIT  = 3'd3,
        S_DATA_BITS  = 3'd4,
`ifdef DUMP_PARITY_EN
        S_PARITY_BIT = 3'd5,
`endif
        S_STOP_BIT   = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [15:0]       timer_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;
`ifdef DUMP_PARITY_EN
    logic              parity_q;
`endif

    // Next address wraps naturally at 2^ADDR_W; tick marks the last cycle of
    // the current bit (or of the read-latency wait).
    logic [ADDR_W-1:0] addr_next_d;
    logic              tick_d;
    assign addr_next_d = d_addr_q + ADDR_W'(1);
    assign tick_d      = (timer_q == 16'd0);

    // Dump sequencer: memory read, UART framing and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            d_addr_q    <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DUMP_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            // Strobes default low; only the entry into READ raises rd_en.
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        d_addr_q    <= base_addr;
                        remaining_q <= length;
                        busy_q      <= 1'b1;
                        if (length == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                    timer_q <= LAT_LAST;
                end
                S_WAIT: begin
                    if (tick_d) begin
                        // Byte is captured; the address may now move on.
                        shift_q     <= rd_data[7:0];
`ifdef DUMP_PARITY_EN
                        parity_q    <= ^rd_data[7:0];
`endif
                        d_addr_q    <= addr_next_d;
                        remaining_q <= remaining_q - (ADDR_W + 1)'(1);
                        state_q     <= S_START_BIT;
                        timer_q     <= BIT_LAST;
                        tx_q        <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_START_BIT: begin
                    if (tick_d) begin
                        state_q   <= S_DATA_BITS;
                        timer_q   <= BIT_LAST;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DATA_BITS: begin
                    if (tick_d) begin
                        timer_q <= BIT_LAST;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
`ifdef DUMP_PARITY_EN
                            state_q <= S_PARITY_BIT;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP_BIT;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // tx is registered, so present the next bit now.
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
`ifdef DUMP_PARITY_EN
                S_PARITY_BIT: begin
                    if (tick_d) begin
                        state_q <= S_STOP_BIT;
                        timer_q <= BIT_LAST;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
`endif
                S_STOP_BIT: begin
                    if (tick_d) begin
                        if (remaining_q != '0) begin
                            state_q <= S_READ;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d_addr = d_addr_q;
    assign rd_en  = rd_en_q;
    assign tx     = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_uart_dumper.sv
// ============================================================================
//  Module   : tb_dram_uart_dumper
//  Purpose  : Self-checking bench for dram_uart_dumper. A cycle-level
//             expectation of tx / rd_en / d_addr / done / busy is derived from
//             the framing rules, with a behavioural dRam of fixed latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_uart_dumper;

    localparam int ADDR_W = 19;
    localparam int CPB    = 4;
    localparam int RD_LAT = 1;
`ifdef DUMP_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR        = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR        = 1'b0;
`endif
    // Cycles per byte: READ + WAIT + the UART frame.
    localparam int P       = 1 + RD_LAT + FRAME_BITS * CPB;
    localparam int PAR_CYC = PAR ? CPB : 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic [ADDR_W-1:0] d_addr;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              tx;
    logic              busy;
    logic              done;

    dram_uart_dumper #(
        .ADDR_W(ADDR_W), .DATA_W(8), .CLKS_PER_BIT(CPB), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .d_addr(d_addr), .rd_en(rd_en), .rd_data(rd_data),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural dRam with RD_LAT-cycle read pipeline.
    bit   [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[d_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RD_LAT-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Current dump as seen by the reference model.
    logic [ADDR_W-1:0] cur_base;
    int                cur_len;
    logic [7:0]        cur_bytes [4];

    // Expected outputs c cycles after the start edge, from framing arithmetic.
    function automatic void model(input int c, output bit m_tx, output bit m_rd,
                                  output bit m_done, output bit m_busy,
                                  output logic [ADDR_W-1:0] m_addr);
        int d = 2 + cur_len * P;
        m_tx   = 1'b1;
        m_rd   = 1'b0;
        m_addr = '0;
        m_done = (c == d);
        m_busy = (c < d);
        for (int i = 0; i < cur_len; i++) begin
            int b = 1 + i * P;
            int o = c - b - (1 + RD_LAT);
            if (c == b) begin
                m_rd   = 1'b1;
                m_addr = ADDR_W'(int'(cur_base) + i);
            end
            if (o >= 0 && o < FRAME_BITS * CPB) begin
                int k = o / CPB;
                if (k == 0)                 m_tx = 1'b0;
                else if (k <= 8)            m_tx = cur_bytes[i][k-1];
                else if (PAR && k == 9)     m_tx = ^cur_bytes[i];
                else                        m_tx = 1'b1;
            end
        end
    endfunction

    // One dump: preload memory, pulse start, compare every cycle, and
    // optionally pulse a stray start (base 0x100) at cycle intr.
    task automatic run_dump(input logic [ADDR_W-1:0] b, input int n,
                            input int exp_done, input int intr);
        int last = 2 + n * P + 3;
        int first_done = -1;
        int rdc = 0;
        bit m_tx, m_rd, m_done, m_busy;
        logic [ADDR_W-1:0] m_addr;
        cur_base = b;
        cur_len  = n;
        for (int i = 0; i < n; i++) mem[ADDR_W'(int'(b) + i)] = cur_bytes[i];
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = (ADDR_W + 1)'(n);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            model(c, m_tx, m_rd, m_done, m_busy, m_addr);
            check($sformatf("trace{tx,rd,done,busy} base=%0h c=%0d", b, c),
                  {28'd0, tx, rd_en, done, busy}, {28'd0, m_tx, m_rd, m_done, m_busy});
            if (m_rd) check($sformatf("rd_addr c=%0d", c), 32'(d_addr), 32'(m_addr));
            if (rd_en) rdc++;
            if (done && first_done < 0) first_done = c;
            if (intr > 0 && c == intr) begin
                start     = 1'b1;
                base_addr = 19'h00100;
                length    = 20'd5;
            end
            if (intr > 0 && c == intr + 1) start = 1'b0;
        end
        check($sformatf("done_cycle base=%0h", b), 32'(first_done), 32'(exp_done));
        check($sformatf("rd_count base=%0h", b), 32'(rdc), 32'(n));
    endtask

    typedef struct packed {
        logic [18:0] base;
        logic [7:0]  len;
        logic [23:0] bytes;     // byte i in bits [8*i +: 8]
        logic [15:0] done_cyc;  // 8N1 done-pulse cycle after start
        logic [7:0]  intr;      // cycle of a stray start, 0 = none
    } vec_t;

    vec_t tbl [7];

    initial begin
        int tx_low, done_hits, busy_hits;

        tbl[0] = '{19'h00010, 8'd1, 24'h0000A5, 16'd44,  8'd0};
        tbl[1] = '{19'h7FFFE, 8'd3, 24'h332211, 16'd128, 8'd0};
        tbl[2] = '{19'h00000, 8'd0, 24'h000000, 16'd2,   8'd0};
        tbl[3] = '{19'h7FFFF, 8'd1, 24'h000007, 16'd44,  8'd0};
        tbl[4] = '{19'h00400, 8'd1, 24'h000003, 16'd44,  8'd0};
        tbl[5] = '{19'h00020, 8'd2, 24'h00C35A, 16'd86,  8'd10};
        tbl[6] = '{19'h12345, 8'd2, 24'h0000FF, 16'd86,  8'd0};

        // Reset held with random start activity.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            check("reset{tx,busy,done,rd_en}", {28'd0, tx, busy, done, rd_en}, 32'h8);
            check("reset d_addr", 32'(d_addr), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        done_hits = 0;
        tx_low    = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_hits++;
            if (!tx || busy || rd_en) tx_low++;
        end
        check("post-reset done pulses", 32'(done_hits), 32'd0);
        check("post-reset idle outputs", 32'(tx_low), 32'd0);

        // Table of directed dumps.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 3; i++) cur_bytes[i] = tbl[t].bytes[8*i +: 8];
            run_dump(tbl[t].base, int'(tbl[t].len),
                     int'(tbl[t].done_cyc) + int'(tbl[t].len) * PAR_CYC, int'(tbl[t].intr));
        end

        // Reset during DATA_BITS of an all-zero byte.
        cur_bytes[0] = 8'h00;
        cur_bytes[1] = 8'h00;
        mem[19'h00200] = 8'h00;
        mem[19'h00201] = 8'h00;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 19'h00200;
        length    = 20'd2;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("pre-abort tx data bit", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort{tx,busy,done,rd_en}", {28'd0, tx, busy, done, rd_en}, 32'h8);
        check("abort d_addr", 32'(d_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_hits = 0;
        tx_low    = 0;
        busy_hits = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done)  done_hits++;
            if (!tx)   tx_low++;
            if (busy || rd_en) busy_hits++;
        end
        check("abort no done", 32'(done_hits), 32'd0);
        check("abort tx idle", 32'(tx_low), 32'd0);
        check("abort stays idle", 32'(busy_hits), 32'd0);

        // Randomized dumps, some straddling the address wrap.
        for (int r = 0; r < 18; r++) begin
            logic [ADDR_W-1:0] b;
            int n;
            n = int'($urandom_range(0, 3));
            b = (r % 4 == 0) ? ADDR_W'(19'h7FFFF - $urandom_range(0, 2)) : ADDR_W'($urandom);
            for (int i = 0; i < 4; i++) cur_bytes[i] = 8'($urandom);
            run_dump(b, n, 2 + n * P, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
